lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side partner of the 8-bit Galois LFSR pattern generator.
- Accepts the generator's 8-bit word stream, self-synchronises to it, predicts every following word and counts mismatches.
- Sits at the sink end of LFSR test links and BIST loops; reports lock status and error statistics.

Parameters:
- SYNC_CNT, 4, number of consecutive correct predictions required to declare lock (range 1..15).
- LOSS_CNT, 3, number of consecutive mismatches while locked that force a return to hunt (range 1..15).
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is presented this cycle.
- in_data  in  8  received LFSR word.
- locked  out  1  checker is synchronised to the stream.
- err_pulse  out  1  one-cycle pulse: the word accepted on the previous cycle mismatched while locked.
- err_cnt  out  CNT_W  saturating count of locked mismatches.
- expected  out  8  predicted value of the next word.

Behaviour:
- Reset: the synchronous reset `rst` (active-high) is sampled on the rising edge of `clk`. Reset values:
  - state = HUNT
  - locked = 0, err_pulse = 0, err_cnt = 0
  - expected = 0x00
  - match_cnt = 0, miss_cnt = 0
- Reset mid-operation discards all state on that edge.
- Next-state function nxt(s):
  - nxt(s) = rotl1(s) XOR (s[7] ? 0x70 : 0x00).
  - Equivalently: n0=s7, n1=s0, n2=s1, n3=s2, n4=s3^s7, n5=s4^s7, n6=s5^s7, n7=s6.
  - Example sequence: 0x97→0x5F→0xBE→0x0D→0x1A→0x34→0x68→0xD0→0xD1.
- Words with in_valid=0 are ignored entirely: no state, counter or prediction change.
- HUNT:
  - A valid nonzero word seeds the predictor: expected <= nxt(in_data), match_cnt <= 0, go to VERIFY.
  - A valid 0x00 word is ignored (lock-up state) and the FSM stays in HUNT.
- VERIFY:
  - Valid word == expected: match_cnt++ and expected <= nxt(expected).
  - When match_cnt reaches SYNC_CNT: go to LOCKED and assert locked on the same edge.
  - Valid word != expected: reseed from that word exactly as in HUNT (a zero word goes to HUNT). err_cnt is not touched.
- LOCKED:
  - expected always advances (flywheel): expected <= nxt(expected). It is never reseeded from data.
  - Match: miss_cnt <= 0.
  - Mismatch: err_pulse = 1 on the following cycle, err_cnt increments and saturates at all-ones, miss_cnt++.
  - When miss_cnt reaches LOSS_CNT: go to HUNT, locked <= 0, expected <= 0x00. err_cnt is retained.
- Latency: every output is registered; a response appears one cycle after the word that caused it.
- Deasserting in_valid mid-lock holds all state indefinitely.
- err_cnt clears only on reset.

Optional Feature:
- Macro: LFSR_FLAG_CHECK_EN.
- When defined, the block adds:
  - input in_flags[2:0]
  - output flag_err_cnt[CNT_W-1:0]
- The generator registers its divisibility flags from the word preceding the current one. The checker therefore holds prev_word, the last accepted expected value.
- On each valid word while locked, the checker compares in_flags with {prev_word%2==0, prev_word%3==0, prev_word%5==0}. On a difference, flag_err_cnt increments, saturating.
- The flag check is skipped on the first valid word after lock.
- When the macro is undefined, the ports and logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W = 8
  - LFSR_TAP_MASK = 8'h70
  - LFSR_SEED = 8'h97
  - the nxt() function
  - the state enum {HUNT, VERIFY, LOCKED}
- The generator will be migrated to lfsr_pkg as well.
- Sub-module lfsr_div_flags: combinational 8-bit %2/%3/%5 flag generator, used only under LFSR_FLAG_CHECK_EN.

Test Plan:
- Reset, then a valid stream 0x97,0x5F,0xBE,0x0D,0x1A → locked=1 after the 0x1A edge, expected=0x34, err_cnt=0.
- Locked, then 0x34 replaced by 0x35, then the correct sequence continues → one err_pulse, err_cnt=1, locked stays 1, and the next word 0x68 matches.
- Locked, then 3 consecutive wrong words → err_cnt=3, locked=0 after the third, state HUNT.
- In HUNT, a valid 0x00 followed by 0x97 → the 0x00 is ignored, the predictor seeds from 0x97, expected=0x5F.
- in_valid gaps of 0–5 cycles inserted randomly into a correct stream → lock is achieved and held, err_cnt=0.
- With LFSR_FLAG_CHECK_EN: locked on a correct stream with flags for 0x97 (000) and then 0x5F (001) lagging by one word → flag_err_cnt=0. A corrupted flag → flag_err_cnt=1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR generator/checker pair.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 8'h70;
    localparam logic [LFSR_W-1:0] LFSR_SEED     = 8'h97;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // One LFSR step: rotate left by one, fold the tap mask in when the MSB was set.
    function automatic logic [LFSR_W-1:0] nxt(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_W-1]} ^ (s[LFSR_W-1] ? LFSR_TAP_MASK : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/lfsr_div_flags.sv
// Combinational divisibility flags {%2==0, %3==0, %5==0} of an LFSR word.
module lfsr_div_flags
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] word,
    output logic [2:0]        flags_c
);

    // Constant-divisor remainders; small enough to map to plain logic.
    always_comb begin
        flags_c    = 3'b000;
        flags_c[2] = ((word % LFSR_W'(2)) == LFSR_W'(0));
        flags_c[1] = ((word % LFSR_W'(3)) == LFSR_W'(0));
        flags_c[0] = ((word % LFSR_W'(5)) == LFSR_W'(0));
    end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the generator stream,
// flywheels the prediction once locked and counts locked mismatches.
// Optional divisibility-flag check is enabled by defining LFSR_FLAG_CHECK_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned SYNC_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
`ifdef LFSR_FLAG_CHECK_EN
    input  logic [2:0]        in_flags,
`endif
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [LFSR_W-1:0] expected
`ifdef LFSR_FLAG_CHECK_EN
    ,
    output logic [CNT_W-1:0]  flag_err_cnt
`endif
);

    localparam int unsigned RUN_W = 4;
    localparam logic [RUN_W-1:0] SYNC_LAST = RUN_W'(SYNC_CNT - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_CNT - 1);

    chk_state_t       state;
    logic [RUN_W-1:0] match_cnt;
    logic [RUN_W-1:0] miss_cnt;
    logic             word_nz;
    logic             word_hit;

    assign word_nz  = |in_data;
    assign word_hit = (in_data == expected);

    // Hunt / verify / locked sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (word_nz) begin
                            expected  <= nxt(in_data);
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (word_hit) begin
                            expected <= nxt(expected);
                            if (match_cnt == SYNC_LAST) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + RUN_W'(1);
                            end
                        end else if (word_nz) begin
                            expected  <= nxt(in_data);
                            match_cnt <= '0;
                        end else begin
                            // A zero word cannot seed; drop the prediction like a loss of lock.
                            state     <= HUNT;
                            expected  <= '0;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (word_hit) begin
                            miss_cnt <= '0;
                            expected <= nxt(expected);
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != {CNT_W{1'b1}}) begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                            if (miss_cnt == LOSS_LAST) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                expected <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + RUN_W'(1);
                                expected <= nxt(expected);
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_FLAG_CHECK_EN
    logic [LFSR_W-1:0] prev_word;
    logic              flag_armed;
    logic [2:0]        prev_flags_c;

    lfsr_div_flags u_div_flags (
        .word    (prev_word),
        .flags_c (prev_flags_c)
    );

    // Flags arrive one word late, so compare against the previous prediction.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word    <= '0;
            flag_armed   <= 1'b0;
            flag_err_cnt <= '0;
        end else if (state == LOCKED) begin
            if (in_valid) begin
                prev_word  <= expected;
                flag_armed <= 1'b1;
                if (flag_armed && (in_flags != prev_flags_c) &&
                    (flag_err_cnt != {CNT_W{1'b1}})) begin
                    flag_err_cnt <= flag_err_cnt + CNT_W'(1);
                end
            end
        end else begin
            flag_armed <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus a randomized
// stream compared against a behavioural model.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int SYNC = 4;
    localparam int LOSS = 3;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic [2:0]    in_flags;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;
    logic [7:0]    expected;
`ifdef LFSR_FLAG_CHECK_EN
    logic [CW-1:0] flag_err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int m_mode;     // 0 hunt, 1 verify, 2 locked
    int m_exp, m_run, m_miss, m_err, m_pulse, m_locked;
    int m_prev, m_armed, m_ferr;

    // Generator state for stimulus
    int gw, gp;

    lfsr_checker #(.SYNC_CNT(SYNC), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
`ifdef LFSR_FLAG_CHECK_EN
        .in_flags     (in_flags),
`endif
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_cnt      (err_cnt),
        .expected     (expected)
`ifdef LFSR_FLAG_CHECK_EN
        ,
        .flag_err_cnt (flag_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    // Multiply by x modulo x^8+x^6+x^5+x^4+1.
    function automatic int nxt_m(input int s);
        int r;
        r = s * 2;
        if (r >= 256) r = r ^ 'h171;
        return r;
    endfunction

    function automatic logic [2:0] div_m(input int p);
        return {(p % 2) == 0, (p % 3) == 0, (p % 5) == 0};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_err = 0;
        m_pulse = 0; m_locked = 0; m_prev = 0; m_armed = 0; m_ferr = 0;
    endtask

    task automatic model_step(input bit v, input int d, input logic [2:0] f);
        m_pulse = 0;
        if (!v) return;
        if (m_mode == 0) begin
            if (d != 0) begin m_exp = nxt_m(d); m_run = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (d == m_exp) begin
                m_exp = nxt_m(m_exp);
                m_run++;
                if (m_run == SYNC) begin m_mode = 2; m_locked = 1; m_miss = 0; m_armed = 0; end
            end else if (d != 0) begin
                m_exp = nxt_m(d); m_run = 0;
            end else begin
                m_mode = 0; m_exp = 0; m_run = 0;
            end
        end else begin
            if (m_armed != 0 && f != div_m(m_prev) && m_ferr < CMAX) m_ferr++;
            m_prev  = m_exp;
            m_armed = 1;
            if (d == m_exp) begin
                m_miss = 0;
                m_exp  = nxt_m(m_exp);
            end else begin
                m_pulse = 1;
                if (m_err < CMAX) m_err++;
                m_miss++;
                if (m_miss == LOSS) begin
                    m_mode = 0; m_locked = 0; m_exp = 0; m_miss = 0;
                end else begin
                    m_exp = nxt_m(m_exp);
                end
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, compare just after it.
    task automatic step(input bit v, input int d, input logic [2:0] f, input bit r);
        @(negedge clk);
        rst = r; in_valid = v; in_data = 8'(d); in_flags = f;
        @(posedge clk);
        if (r) model_reset();
        else model_step(v, d, f);
        #1;
        check("locked", 32'(locked), 32'(m_locked));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("expected", 32'(expected), 32'(m_exp));
`ifdef LFSR_FLAG_CHECK_EN
        check("flag_err_cnt", 32'(flag_err_cnt), 32'(m_ferr));
`endif
    endtask

    task automatic send_good();
        step(1, gw, div_m(gp), 0);
        gp = gw;
        gw = nxt_m(gw);
    endtask

    task automatic do_reset();
        step(0, 0, 3'b000, 1);
        step(0, 0, 3'b000, 1);
        gw = int'(LFSR_SEED);
        gp = 0;
    endtask

    initial begin
        int v, d, sd;
        logic [2:0] f;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_flags = '0;
        model_reset();

        // Reset values
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_expected", 32'(expected), 0);

        // Acquire lock on the reference sequence
        repeat (5) send_good();
        check("lock_locked", 32'(locked), 1);
        check("lock_expected", 32'(expected), 32'h34);
        check("lock_err_cnt", 32'(err_cnt), 0);

        // Single corrupted word while locked
        step(1, 'h35, div_m(gp), 0);
        gp = gw; gw = nxt_m(gw);
        check("hit1_pulse", 32'(err_pulse), 1);
        check("hit1_err_cnt", 32'(err_cnt), 1);
        check("hit1_locked", 32'(locked), 1);
        send_good();
        check("hit1_recover_pulse", 32'(err_pulse), 0);
        check("hit1_recover_expected", 32'(expected), 32'hD0);

        // Three consecutive wrong words drop lock
        repeat (2) begin
            step(1, gw ^ 'h01, div_m(gp), 0);
            gp = gw; gw = nxt_m(gw);
        end
        check("loss_still_locked", 32'(locked), 1);
        step(1, gw ^ 'h01, div_m(gp), 0);
        check("loss_locked", 32'(locked), 0);
        check("loss_err_cnt", 32'(err_cnt), 4);
        check("loss_expected", 32'(expected), 0);

        // Zero word in HUNT is ignored, then reseed from the seed word
        step(1, 0, 3'b000, 0);
        check("zero_ignored", 32'(expected), 0);
        step(1, 'h97, 3'b000, 0);
        check("reseed_expected", 32'(expected), 32'h5F);
        check("reseed_err_cnt", 32'(err_cnt), 4);

        // Correct stream with random gaps from a random seed
        do_reset();
        gw = int'($urandom_range(1, 255));
        repeat (30) begin
            repeat ($urandom_range(0, 5)) step(0, int'($urandom_range(0, 255)), 3'($urandom), 0);
            send_good();
        end
        check("gap_locked", 32'(locked), 1);
        check("gap_err_cnt", 32'(err_cnt), 0);
`ifdef LFSR_FLAG_CHECK_EN
        check("gap_flag_err", 32'(flag_err_cnt), 0);
        step(1, gw, div_m(gp) ^ 3'b010, 0);
        gp = gw; gw = nxt_m(gw);
        check("flag_corrupt", 32'(flag_err_cnt), 1);
`endif

        // Randomized stream: gaps, corrupted words, zeros, jumps and resets
        for (int i = 0; i < 3000; i++) begin
            sd = int'($urandom_range(0, 999));
            if (sd < 4) begin
                step(0, 0, 3'b000, 1);
                gp = 0;
                continue;
            end
            if (sd < 14) gw = int'($urandom_range(1, 255));
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d = gw;
            sd = int'($urandom_range(0, 99));
            if (sd < 6) d = int'($urandom_range(0, 255));
            else if (sd < 7) d = 0;
            f = div_m(gp);
            if ($urandom_range(0, 99) < 3) f = f ^ 3'($urandom_range(1, 7));
            step(v[0], d, f, 0);
            if (v != 0) begin
                gp = gw;
                gw = nxt_m(gw);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
